// File: rtl/fifo_rd_arbiter.sv
// fifo_rd_arbiter: round-robin read scheduler that drains up to BURST words
// from one of NUM_CH single-clock FIFOs per grant. Each word is captured from
// the FIFO's registered dout and presented on a tagged valid/ready stream.
//
// Handshake: m_valid is high whenever the 2-entry output queue holds a word.
// A word transfers on a cycle where m_valid & m_ready. While m_valid is high
// and m_ready is low, m_data and m_ch hold stable. m_valid never waits on
// m_ready.
module fifo_rd_arbiter #(
  parameter int DW     = 12,
  parameter int NUM_CH = 4,
  parameter int BURST  = 8,
  parameter int CW     = $clog2(NUM_CH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_CH-1:0]    fifo_empty,
  input  logic [NUM_CH*DW-1:0] fifo_dout,
  output logic [NUM_CH-1:0]    fifo_rd_en,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [DW-1:0]        m_data,
  output logic [CW-1:0]        m_ch,
  output logic                 busy,
  output logic                 dbg_state
);

  localparam int            BW        = $clog2(BURST + 1);
  localparam logic [BW-1:0] BEAT_LAST = BW'(BURST - 1);
  localparam logic [CW-1:0] CH_LAST   = CW'(NUM_CH - 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_e;

  state_e        state_q;
  logic [CW-1:0] grant_q;
  logic [CW-1:0] last_grant_q;
  logic [BW-1:0] beat_q;
  logic          pend_q;
  logic [CW-1:0] pend_ch_q;

  // Two-slot output queue, addressed by single-bit pointers.
  logic [DW-1:0] q_data_q [2];
  logic [CW-1:0] q_ch_q   [2];
  logic          wr_ptr_q;
  logic          rd_ptr_q;
  logic [1:0]    occ_q;
  logic [1:0]    occ_d;

  logic          push;
  logic          pop;
  logic [2:0]    fill;
  logic          space;
  logic          issue;
  logic          scan_found;
  logic [CW-1:0] scan_ch;
  logic [CW-1:0] cand;
  logic [DW-1:0] cap_data;

  // Round-robin scan starting after last_grant; wrap is explicit so that a
  // non-power-of-two channel count never produces an out-of-range index.
  always_comb begin
    scan_found = 1'b0;
    scan_ch    = '0;
    cand       = last_grant_q;
    for (int i = 0; i < NUM_CH; i++) begin
      cand = (cand == CH_LAST) ? '0 : cand + CW'(1);
      if (!scan_found && !fifo_empty[cand]) begin
        scan_found = 1'b1;
        scan_ch    = cand;
      end
    end
  end

  // Credit check: a read may issue only if the queue can still take the word
  // it returns next cycle, counting a word already in flight and a pop now.
  always_comb begin
    pop   = m_valid & m_ready;
    push  = pend_q;
    fill  = {1'b0, occ_q} + {2'b00, pend_q} - {2'b00, pop};
    space = (fill < 3'd2);
    issue = (state_q == ST_BURST) & ~fifo_empty[grant_q] & space;
  end

  // Read strobe goes only to the granted channel, and only when it has data.
  always_comb begin
    fifo_rd_en = '0;
    if (issue) fifo_rd_en[grant_q] = 1'b1;
  end

  // Grant/burst state machine plus the one-cycle in-flight read tracker.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      last_grant_q <= CH_LAST;
      beat_q       <= '0;
      pend_q       <= 1'b0;
      pend_ch_q    <= '0;
    end else begin
      pend_q    <= issue;
      pend_ch_q <= grant_q;
      case (state_q)
        ST_IDLE: begin
          if (scan_found) begin
            grant_q      <= scan_ch;
            last_grant_q <= scan_ch;
            beat_q       <= '0;
            state_q      <= ST_BURST;
          end
        end
        ST_BURST: begin
          if (fifo_empty[grant_q]) begin
            state_q <= ST_IDLE;
          end else if (issue) begin
            beat_q <= beat_q + BW'(1);
            if (beat_q == BEAT_LAST) state_q <= ST_IDLE;
          end
        end
      endcase
    end
  end

  // Next occupancy: a simultaneous push and pop leaves it unchanged.
  always_comb begin
    occ_d = occ_q;
    case ({push, pop})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
  end

  assign cap_data = fifo_dout[pend_ch_q*DW +: DW];

  // Output queue: capture the word read last cycle, advance head on pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_data_q[0] <= '0;
      q_data_q[1] <= '0;
      q_ch_q[0]   <= '0;
      q_ch_q[1]   <= '0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      occ_q       <= 2'd0;
    end else begin
      if (push) begin
        q_data_q[wr_ptr_q] <= cap_data;
        q_ch_q[wr_ptr_q]   <= pend_ch_q;
        wr_ptr_q           <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      occ_q <= occ_d;
    end
  end

  assign m_valid   = (occ_q != 2'd0);
  assign m_data    = q_data_q[rd_ptr_q];
  assign m_ch      = q_ch_q[rd_ptr_q];
  assign busy      = (state_q == ST_BURST) | pend_q | (occ_q != 2'd0);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_fifo_rd_arbiter.sv
// Bench for fifo_rd_arbiter with three channels (non-power-of-two wrap).
module tb_fifo_rd_arbiter;
  localparam int DW     = 12;
  localparam int NUM_CH = 3;
  localparam int BURST  = 8;
  localparam int CW     = $clog2(NUM_CH);
  localparam int DEPTH  = 256;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [NUM_CH-1:0]    fifo_empty;
  logic [NUM_CH*DW-1:0] fifo_dout;
  logic [NUM_CH-1:0]    fifo_rd_en;
  logic                 m_valid;
  logic                 m_ready;
  logic [DW-1:0]        m_data;
  logic [CW-1:0]        m_ch;
  logic                 busy;
  logic                 dbg_state;

  fifo_rd_arbiter #(.DW(DW), .NUM_CH(NUM_CH), .BURST(BURST)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .fifo_empty (fifo_empty),
    .fifo_dout  (fifo_dout),
    .fifo_rd_en (fifo_rd_en),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_ch       (m_ch),
    .busy       (busy),
    .dbg_state  (dbg_state)
  );

  // ---------------- FIFO models (registered dout, shared reset) ----------------
  logic [DW-1:0] mem [NUM_CH][DEPTH];
  int            wr_ptr [NUM_CH];
  int            rd_ptr [NUM_CH];
  logic [DW-1:0] dout_q [NUM_CH];

  for (genvar g = 0; g < NUM_CH; g++) begin : g_fifo
    assign fifo_empty[g]         = (rd_ptr[g] == wr_ptr[g]);
    assign fifo_dout[g*DW +: DW] = dout_q[g];
  end

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (!rst_n) begin
        rd_ptr[i] <= wr_ptr[i];
        dout_q[i] <= '0;
      end else if (fifo_rd_en[i] && (rd_ptr[i] != wr_ptr[i])) begin
        dout_q[i] <= mem[i][rd_ptr[i]];
        rd_ptr[i] <= rd_ptr[i] + 1;
      end
    end
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  logic [CW+DW-1:0] exp_q[$];

  // ---------------- scoreboard monitor (negedge sampling) ----------------
  logic             hold_pend = 1'b0;
  logic [CW+DW-1:0] hold_word;

  always @(negedge clk) begin
    if (!rst_n) begin
      hold_pend = 1'b0;
    end else begin
      if (hold_pend) check("hold_stable", {m_valid, m_ch, m_data}, {1'b1, hold_word});
      hold_pend = m_valid && !m_ready;
      hold_word = {m_ch, m_data};
      if (fifo_rd_en != '0)
        check("rd_en_legal", {31'd0, $onehot(fifo_rd_en) && ((fifo_rd_en & fifo_empty) == '0)}, 1);
      if (m_valid && m_ready) begin
        check("sb_expected_word_present", {31'd0, exp_q.size() != 0}, 1);
        if (exp_q.size() != 0) check("sb_word", {m_ch, m_data}, exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int ch, input logic [DW-1:0] d);
    mem[ch][wr_ptr[ch]] = d;
    wr_ptr[ch] = wr_ptr[ch] + 1;
  endtask

  task automatic expect_word(input int ch, input logic [DW-1:0] d);
    exp_q.push_back({CW'(ch), d});
  endtask

  function automatic int onehot_idx(input logic [NUM_CH-1:0] v);
    int r = -1;
    for (int i = 0; i < NUM_CH; i++) if (v[i]) r = i;
    return r;
  endfunction

  // Run until everything drains, logging contiguous read runs per channel.
  int run_ch[$];
  int run_len[$];
  int erun_ch[$];
  int erun_len[$];
  int first_valid;
  int mv_run_max;

  task automatic run_log(input int max_cyc, input string tag);
    logic [NUM_CH-1:0] prev;
    bit done;
    int mv_run;
    run_ch.delete();
    run_len.delete();
    first_valid = -1;
    mv_run      = 0;
    mv_run_max  = 0;
    prev        = '0;
    done        = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      tick();
      if (fifo_rd_en != '0) begin
        if (fifo_rd_en != prev) begin
          run_ch.push_back(onehot_idx(fifo_rd_en));
          run_len.push_back(1);
        end else begin
          run_len[run_len.size()-1] = run_len[run_len.size()-1] + 1;
        end
      end
      prev = fifo_rd_en;
      if (m_valid) begin
        if (first_valid < 0) first_valid = i + 1;
        mv_run++;
        if (mv_run > mv_run_max) mv_run_max = mv_run;
      end else begin
        mv_run = 0;
      end
      if (!busy && (fifo_empty == '1) && (exp_q.size() == 0)) begin
        done = 1'b1;
        break;
      end
    end
    check({tag, "_drained"}, {31'd0, done}, 1);
    check({tag, "_sb_empty"}, exp_q.size(), 0);
    check({tag, "_idle_state"}, {31'd0, dbg_state}, 0);
  endtask

  task automatic check_runs(input string tag);
    check({tag, "_num_runs"}, run_ch.size(), erun_ch.size());
    for (int k = 0; k < erun_ch.size(); k++) begin
      if (k < run_ch.size()) begin
        check($sformatf("%s_run%0d_ch", tag, k), run_ch[k], erun_ch[k]);
        check($sformatf("%s_run%0d_len", tag, k), run_len[k], erun_len[k]);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  logic [DW-1:0] w0 [20];
  logic [DW-1:0] w1 [5];
  int reads;

  initial begin
    rst_n   = 1'b0;
    m_ready = 1'b0;
    repeat (3) tick();

    // Reset values
    check("rst_rd_en", {29'd0, fifo_rd_en}, 0);
    check("rst_m_valid", {31'd0, m_valid}, 0);
    check("rst_m_data", {20'd0, m_data}, 0);
    check("rst_m_ch", {30'd0, m_ch}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_state", {31'd0, dbg_state}, 0);
    rst_n   = 1'b1;
    m_ready = 1'b1;
    tick();

    // Single channel: ch2 holds three words
    load(2, 12'h011); load(2, 12'h022); load(2, 12'h033);
    expect_word(2, 12'h011); expect_word(2, 12'h022); expect_word(2, 12'h033);
    run_log(40, "t1");
    erun_ch  = '{2};
    erun_len = '{3};
    check_runs("t1");
    check("t1_latency", first_valid, 3);
    check("t1_valid_consecutive", mv_run_max, 3);
    check("t1_busy", {31'd0, busy}, 0);

    // Burst cap: ch0 20 words, ch1 5 words
    for (int k = 0; k < 20; k++) begin
      w0[k] = DW'($urandom_range(0, 4095));
      load(0, w0[k]);
    end
    for (int k = 0; k < 5; k++) begin
      w1[k] = DW'($urandom_range(0, 4095));
      load(1, w1[k]);
    end
    for (int k = 0; k < 8; k++)   expect_word(0, w0[k]);
    for (int k = 0; k < 5; k++)   expect_word(1, w1[k]);
    for (int k = 8; k < 20; k++)  expect_word(0, w0[k]);
    run_log(300, "t2");
    erun_ch  = '{0, 1, 0, 0};
    erun_len = '{8, 5, 8, 4};
    check_runs("t2");

    // Round-robin wrap: first make ch2 the last grant, then all three
    load(2, 12'h0A2); expect_word(2, 12'h0A2);
    run_log(40, "t4a");
    erun_ch  = '{2};
    erun_len = '{1};
    check_runs("t4a");
    load(0, 12'h700); load(1, 12'h711); load(2, 12'h722);
    expect_word(0, 12'h700); expect_word(1, 12'h711); expect_word(2, 12'h722);
    run_log(60, "t4b");
    erun_ch  = '{0, 1, 2};
    erun_len = '{1, 1, 1};
    check_runs("t4b");
    load(0, 12'h7F0); expect_word(0, 12'h7F0);
    run_log(40, "t4c");
    erun_ch  = '{0};
    erun_len = '{1};
    check_runs("t4c");

    // Backpressure: 4-word burst on ch1 with m_ready low for 5 cycles
    m_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      load(1, DW'(12'h301 + k));
      expect_word(1, DW'(12'h301 + k));
    end
    reads = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (fifo_rd_en != '0) reads++;
    end
    check("t3_reads_under_stall", reads, 2);
    check("t3_rd_en_stalled", {29'd0, fifo_rd_en}, 0);
    check("t3_m_valid", {31'd0, m_valid}, 1);
    check("t3_head_data", {20'd0, m_data}, 32'h301);
    check("t3_head_ch", {30'd0, m_ch}, 1);
    m_ready = 1'b1;
    run_log(60, "t3");

    // Simultaneous push/pop: 6-word burst on ch0 streams without a gap
    for (int k = 0; k < 6; k++) begin
      load(0, DW'(12'h401 + k));
      expect_word(0, DW'(12'h401 + k));
    end
    run_log(60, "t5");
    erun_ch  = '{0};
    erun_len = '{6};
    check_runs("t5");
    check("t5_valid_streak", mv_run_max, 6);

    // Reset mid-burst on ch1, asserted during the second beat
    for (int k = 0; k < 6; k++) load(1, DW'(12'h501 + k));
    tick();
    tick();
    check("t6_pre_rd_en", {29'd0, fifo_rd_en}, 32'b010);
    check("t6_pre_busy", {31'd0, busy}, 1);
    rst_n = 1'b0;
    #1;
    check("t6_rst_rd_en", {29'd0, fifo_rd_en}, 0);
    check("t6_rst_m_valid", {31'd0, m_valid}, 0);
    check("t6_rst_busy", {31'd0, busy}, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    load(2, 12'h6AA); load(0, 12'h655);
    expect_word(0, 12'h655); expect_word(2, 12'h6AA);
    run_log(60, "t6");
    erun_ch  = '{0, 2};
    erun_len = '{1, 1};
    check_runs("t6");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
